// File: rtl/dac_spi_tx_if.sv
// Sample/SPI bundle between the modulator-side driver and the DAC serializer.
// The master drives samples in; the slave (dac_spi_tx) returns SPI pins and status.
interface dac_spi_tx_if #(parameter int W = 16);
  logic [W-1:0] i_data;
  logic         val_in;
  logic         o_sclk;
  logic         o_mosi;
  logic         o_cs_n;
  logic         o_busy;
  logic         o_ovf;

  modport master (output i_data, val_in,
                  input  o_sclk, o_mosi, o_cs_n, o_busy, o_ovf);
  modport slave  (input  i_data, val_in,
                  output o_sclk, o_mosi, o_cs_n, o_busy, o_ovf);
endinterface

// File: rtl/dac_spi_tx.sv
// Buffers signed modulator samples in a small FIFO and shifts each one out as
// offset binary, MSB first, over an SPI mode-0 link to an external DAC.
module dac_spi_tx #(
  parameter int W          = 16,
  parameter int CLK_DIV    = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  dac_spi_tx_if.slave  bus
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int BW = $clog2(W + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, GAP} state_t;

  state_t        state_q, state_d;
  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  // MSB goes straight to mosi on pop, so only the remaining bits are kept here
  logic [W-2:0]  sreg_q, sreg_d;
  logic [W-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sclk_q, sclk_d, mosi_q, mosi_d, cs_n_q, cs_n_d;
  logic          busy_q, busy_d, ovf_q, ovf_d;
  logic          full, wr, pop, half_done;
  logic [W-1:0]  head;

  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign wr        = bus.val_in && !full;
  assign head      = mem_q[rptr_q];
  assign half_done = (hcnt_q == HW'(CLK_DIV - 1));

  always_comb begin
    state_d = state_q;
    hcnt_d  = hcnt_q;
    bcnt_d  = bcnt_q;
    sreg_d  = sreg_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    cs_n_d  = cs_n_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop     = 1'b1;
        sreg_d  = head[W-2:0];
        mosi_d  = head[W-1];
        cs_n_d  = 1'b0;
        hcnt_d  = '0;
        state_d = SETUP;
      end
      SETUP: begin
        hcnt_d = hcnt_q + 1'b1;
        if (half_done) begin
          hcnt_d  = '0;
          bcnt_d  = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        hcnt_d = hcnt_q + 1'b1;
        if (half_done) begin
          hcnt_d = '0;
          // sclk_q doubles as the half-period phase: low half, then high half
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bcnt_q == BW'(W - 1)) begin
            sclk_d  = 1'b0;
            mosi_d  = 1'b0;
            cs_n_d  = 1'b1;
            bcnt_d  = '0;
            state_d = GAP;
          end else begin
            sclk_d = 1'b0;
            mosi_d = sreg_q[W-2];
            sreg_d = {sreg_q[W-3:0], 1'b0};
            bcnt_d = bcnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        hcnt_d = hcnt_q + 1'b1;
        if (half_done) begin
          hcnt_d  = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    wptr_d = wr  ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q + CW'(wr) - CW'(pop);
    busy_d = (state_d != IDLE) || (cnt_d != '0);
    ovf_d  = ovf_q || (bus.val_in && full);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      bcnt_q  <= '0;
      sreg_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      sreg_q  <= sreg_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: the pointers and count define what is valid
  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= {~bus.i_data[W-1], bus.i_data[W-2:0]};
  end

  assign bus.o_sclk = sclk_q;
  assign bus.o_mosi = mosi_q;
  assign bus.o_cs_n = cs_n_q;
  assign bus.o_busy = busy_q;
  assign bus.o_ovf  = ovf_q;
endmodule
